ex_operand_stage: RTL

//  ID/EX pipeline register and operand-select stage directly upstream of the ALU.

---
 rtl/rv32_alu_pkg.sv | 32 +++
 rtl/fwd_mux.sv | 38 +++
 rtl/ex_operand_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_alu_pkg.sv
// ALU operation and SrcA-select encodings shared by the execute datapath.
package rv32_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_MIN  = 4'b1011,
    ALU_MAX  = 4'b1100,
    ALU_LT   = 4'b1101,
    ALU_EQ   = 4'b1110,
    ALU_SRA  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'b00,
    ASEL_PC   = 2'b01,
    ASEL_ZERO = 2'b10
  } asel_e;

  // Shift operations consume only the low five bits of SrcB.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: MEM (non-load) beats WB beats the stored value; x0 never bypasses.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] stored,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] operand,
  output logic            load_hit
);

  logic mem_match;
  logic mem_hit;
  logic wb_hit;

  assign mem_match = mem_regwrite & (mem_rd != '0) & (mem_rd == rs);
  assign mem_hit   = mem_match & ~mem_is_load;
  // A load in MEM has no data yet: flag it so the stage can wait instead of bypassing.
  assign load_hit  = mem_match & mem_is_load;
  assign wb_hit    = wb_regwrite & (wb_rd != '0) & (wb_rd == rs);

  always_comb begin
    operand = stored;
    if (mem_hit) begin
      operand = mem_result;
    end else if (wb_hit) begin
      operand = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and ALU operand select.
module ex_operand_stage
  import rv32_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [1:0]        id_asel,
  input  logic              id_bsel,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic              wb_regwrite,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   SrcA,
  output logic [XLEN-1:0]   SrcB,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_is_load,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs2_data
);

  logic              valid_q, valid_d;
  logic [RA_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
  logic [1:0]        asel_q, asel_d;
  logic              bsel_q, bsel_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              regwrite_q, regwrite_d, is_load_q, is_load_d;

  logic [XLEN-1:0]   fwd1, fwd2;
  logic              load_hit1, load_hit2;
  logic              pending, lu, free, accept;
  logic [XLEN-1:0]   srcb_raw;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs(rs1_q), .stored(op1_q),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
    .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .operand(fwd1), .load_hit(load_hit1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs(rs2_q), .stored(op2_q),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
    .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .operand(fwd2), .load_hit(load_hit2)
  );

  assign pending  = valid_q & ((use_rs1_q & load_hit1) | (use_rs2_q & load_hit2));
  assign ex_valid = valid_q & ~pending;
  assign lu       = id_valid & valid_q & is_load_q & (rd_q != '0) &
                    ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
  assign free     = ~valid_q | (ex_valid & ex_ready);
  assign id_ready = free & ~lu & ~flush;
  assign accept   = id_valid & id_ready;

  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    use_rs1_d  = use_rs1_q;
    use_rs2_d  = use_rs2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    asel_d     = asel_q;
    bsel_d     = bsel_q;
    ctrl_d     = ctrl_q;
    regwrite_d = regwrite_q;
    is_load_d  = is_load_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      use_rs1_d  = id_use_rs1;
      use_rs2_d  = id_use_rs2;
      op1_d      = id_rd1;
      op2_d      = id_rd2;
      imm_d      = id_imm;
      pc_d       = id_pc;
      asel_d     = id_asel;
      bsel_d     = id_bsel;
      ctrl_d     = id_alu_ctrl;
      regwrite_d = id_regwrite;
      is_load_d  = id_is_load;
    end else if (free) begin
      valid_d = 1'b0;
    end else begin
      // Held instruction: latch bypassed values so a one-cycle WB forward is not lost.
      op1_d = fwd1;
      op2_d = fwd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      use_rs1_q  <= 1'b0;
      use_rs2_q  <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      asel_q     <= '0;
      bsel_q     <= 1'b0;
      ctrl_q     <= '0;
      regwrite_q <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      use_rs1_q  <= use_rs1_d;
      use_rs2_q  <= use_rs2_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      ctrl_q     <= ctrl_d;
      regwrite_q <= regwrite_d;
      is_load_q  <= is_load_d;
    end
  end

  always_comb begin
    SrcA     = '0;
    srcb_raw = bsel_q ? imm_q : fwd2;
    SrcB     = srcb_raw;
    case (asel_q)
      ASEL_RS1: SrcA = fwd1;
      ASEL_PC:  SrcA = pc_q;
      default:  SrcA = '0;
    endcase
    if (is_shift(ctrl_q)) begin
      SrcB = {{(XLEN-5){1'b0}}, srcb_raw[4:0]};
    end
  end

  assign ALUControl  = ctrl_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_is_load  = is_load_q;
  assign ex_pc       = pc_q;
  assign ex_rs2_data = fwd2;

endmodule
